mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch path (icache/fetch) and the data-memory path (dcache/MEM stage) of the pipelined CPU.
- Registered-grant FSM: holds one grant until the RAM completes, then rearbitrates.
- Data has priority, with a starvation guard for fetch.
- Reports a sticky error flag and a RAM-hang timeout.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while an instruction request waits; then fetch is forced. Range 1..15.
- TIMEOUT, 64: cycles a grant may stay incomplete before `timeout` asserts. Range 2..255.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request (dREN and dWEN are never both high)
- daddr  in  32  data address
- dstore  in  32  data write value
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ramload  in  32  RAM read data
- iwait  out  1  instruction request not yet complete
- dwait  out  1  data request not yet complete
- iload  out  32  instruction read data
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- err  out  1  sticky RAM error
- timeout  out  1  sticky hang indicator

Behaviour:
- States: IDLE, DGRANT, IGRANT. Reset enters IDLE asynchronously.
- Reset values:
  - ram* = 0, iload = dload = 0, err = timeout = 0.
  - iwait = iREN and dwait = dREN|dWEN (pure function of state, so they are 1 if requesting).
  - dstreak = 0, wait counter = 0.
- Reset mid-grant abandons the access. The RAM enables drop immediately.
- IDLE:
  - No RAM enables.
  - Arbitration:
    - If a data request is present and (no iREN, or dstreak < MAX_DSTREAK): go to DGRANT.
    - Else if iREN: go to IGRANT.
    - Else stay in IDLE.
  - Decision registered; one cycle of arbitration latency.
- DGRANT:
  - ramREN = dREN, ramWEN = dWEN, ramaddr = daddr, ramstore = dstore.
  - dwait = 1 until ramstate == ACCESS or ERROR; that cycle dwait = 0 and dload = ramload.
  - Then go to IDLE.
  - dstreak increments (saturating at 15) on completion if iREN is high; otherwise it clears.
- IGRANT:
  - ramREN = 1, ramaddr = iaddr, ramWEN = 0, ramstore = 0.
  - iwait = 0 and iload = ramload on ACCESS/ERROR.
  - Then go to IDLE; dstreak clears.
- Non-granted requester: wait = 1 and load = 0 in every state.
- Requester drops its request while granted:
  - Return to IDLE next cycle.
  - RAM enables follow the live request, so they deassert the same cycle.
- ERROR completes the access like ACCESS and sets err (sticky until reset).
- Wait counter:
  - Counts cycles spent in a grant state; clears in IDLE.
  - Reaching TIMEOUT sets timeout (sticky). The grant is still held.
- Minimum transaction: 2 cycles (IDLE decision + one grant cycle with ACCESS). Each completion is followed by one IDLE cycle, so no back-to-back regrant without IDLE.
- Address/data pass through unregistered during grant; width 32, no translation.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs icount[31:0], dcount[31:0] and stall_cycles[31:0], all reset to 0.
  - icount/dcount increment once per completed instruction/data access.
  - stall_cycles increments each cycle iREN && iwait.
  - All three wrap modulo 2^32.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, ramstate ACCESS with ramload=0x8C220004 -> IGRANT next cycle, ramREN=1, ramaddr=0x40, iwait falls, iload=0x8C220004, then IDLE.
- iREN and dWEN both high in IDLE, daddr=0x100, dstore=0xDEAD -> DGRANT first (ramWEN=1, ramstore=0xDEAD), iwait stays 1; IGRANT follows after one IDLE cycle.
- dREN held continuously with iREN high, MAX_DSTREAK=4 -> exactly 4 DGRANT completions, then IGRANT, then dstreak=0.
- ramstate=BUSY for 3 cycles, then ACCESS during DGRANT -> dwait=1 for 3 grant cycles, 0 on the fourth, with dload valid.
- ramstate=ERROR on completion -> wait falls, err=1 and stays 1 through later good accesses until nRST.
- ramstate held BUSY with TIMEOUT=64 -> timeout=1 after 64 grant cycles; asserting nRST mid-grant clears everything and drops ram enables asynchronously.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares a single-ported RAM between fetch and data paths; data wins
//            with a starvation guard for fetch. Optional MEM_ARB_STATS_EN adds
//            access and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        err,
    output logic        timeout
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [1:0] c_RAM_ACCESS  = 2'd2;
    localparam logic [1:0] c_RAM_ERROR   = 2'd3;
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DGRANT   = 2'd1;
    localparam logic [1:0] c_ST_IGRANT   = 2'd2;
    localparam logic [3:0] c_MAX_DSTREAK = 4'(MAX_DSTREAK);
    localparam logic [7:0] c_TIMEOUT     = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        DGRANT = c_ST_DGRANT,
        IGRANT = c_ST_IGRANT
    } state_t;

    state_t     r_state;
    logic [3:0] r_dstreak;
    logic [7:0] r_wait_cnt;
    logic       r_err;
    logic       r_timeout;

    logic       w_dreq;
    logic       w_ram_done;
    logic       w_dcomplete;
    logic       w_icomplete;
    logic [7:0] w_wait_next;

    assign w_dreq      = dREN | dWEN;
    assign w_ram_done  = (ramstate == c_RAM_ACCESS) || (ramstate == c_RAM_ERROR);
    assign w_dcomplete = (r_state == DGRANT) && w_dreq && w_ram_done;
    assign w_icomplete = (r_state == IGRANT) && iREN && w_ram_done;
    assign w_wait_next = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;

    assign err     = r_err;
    assign timeout = r_timeout;

    // RAM side follows the live request so a dropped request releases the RAM at once
    always_comb begin
        iwait    = iREN;
        dwait    = w_dreq;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_dcomplete) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (w_icomplete) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_dstreak  <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dreq && (!iREN || (r_dstreak < c_MAX_DSTREAK))) begin
                        r_state <= DGRANT;
                    end else if (iREN) begin
                        r_state <= IGRANT;
                    end
                end
                DGRANT: begin
                    if (w_dcomplete) begin
                        r_state <= IDLE;
                        // streak only grows while fetch is actually waiting
                        if (!iREN) begin
                            r_dstreak <= '0;
                        end else if (r_dstreak != 4'hF) begin
                            r_dstreak <= r_dstreak + 4'd1;
                        end
                    end else if (!w_dreq) begin
                        r_state <= IDLE;
                    end
                end
                IGRANT: begin
                    if (w_icomplete || !iREN) begin
                        r_state   <= IDLE;
                        r_dstreak <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (r_state == IDLE) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= w_wait_next;
                if (w_wait_next >= c_TIMEOUT) begin
                    r_timeout <= 1'b1;
                end
            end

            if ((w_dcomplete || w_icomplete) && (ramstate == c_RAM_ERROR)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_icount;
    logic [31:0] r_dcount;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icount       <= '0;
            r_dcount       <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_icomplete) begin
                r_icount <= r_icount + 32'd1;
            end
            if (w_dcomplete) begin
                r_dcount <= r_dcount + 32'd1;
            end
            if (iREN && iwait) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign icount       = r_icount;
    assign dcount       = r_dcount;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed vector table plus hand sequences for streak and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [1:0] c_FREE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_ACC  = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err, timeout;
    logic [31:0] iload, dload, ramaddr, ramstore;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .MAX_DSTREAK(4),
        .TIMEOUT    (64)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .ramstate(ramstate),
        .ramload (ramload),
        .iwait   (iwait),
        .dwait   (dwait),
        .iload   (iload),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .err     (err),
        .timeout (timeout)
    );

    // {iwait, dwait, ramREN, ramWEN, err, timeout, iload, dload, ramaddr, ramstore}
    logic [133:0] w_act;
    assign w_act = {iwait, dwait, ramREN, ramWEN, err, timeout, iload, dload, ramaddr, ramstore};

    typedef struct {
        logic         ire, dre, dwe;
        logic [1:0]   rs;
        logic [31:0]  ia, da, ds, rl;
        logic [133:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ire, dre, dwe, input logic [1:0] rs,
                                input logic [31:0] ia, da, ds, rl,
                                input logic iw, dw, ren, wen, er,
                                input logic [31:0] il, dl, ra, st);
        vec_t v;
        v.ire = ire; v.dre = dre; v.dwe = dwe; v.rs = rs;
        v.ia = ia; v.da = da; v.ds = ds; v.rl = rl;
        v.exp = {iw, dw, ren, wen, er, 1'b0, il, dl, ra, st};
        return v;
    endfunction

    task automatic drive(input logic ire, dre, dwe, input logic [1:0] rs,
                         input logic [31:0] ia, da, ds, rl);
        iREN = ire; dREN = dre; dWEN = dwe; ramstate = rs;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    endtask

    vec_t vecs[22];
    int   exp_seq[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1};

    initial begin
        // fetch, then write-vs-fetch conflict, busy read, error, dropped request
        vecs[0]  = mk(1,0,0,c_ACC, 32'h40,0,0,32'h8C220004, 1,0,0,0,0, 0,0,0,0);
        vecs[1]  = mk(1,0,0,c_ACC, 32'h40,0,0,32'h8C220004, 0,0,1,0,0, 32'h8C220004,0,32'h40,0);
        vecs[2]  = mk(0,0,0,c_FREE,0,0,0,0,                  0,0,0,0,0, 0,0,0,0);
        vecs[3]  = mk(1,0,1,c_BUSY,32'h44,32'h100,32'hDEAD,32'h11111111, 1,1,0,0,0, 0,0,0,0);
        vecs[4]  = mk(1,0,1,c_ACC, 32'h44,32'h100,32'hDEAD,32'h11111111, 1,0,0,1,0, 0,32'h11111111,32'h100,32'hDEAD);
        vecs[5]  = mk(1,0,0,c_ACC, 32'h44,0,0,32'h22222222, 1,0,0,0,0, 0,0,0,0);
        vecs[6]  = mk(1,0,0,c_ACC, 32'h44,0,0,32'h22222222, 0,0,1,0,0, 32'h22222222,0,32'h44,0);
        vecs[7]  = mk(0,1,0,c_BUSY,0,32'h200,32'h55,32'h33333333, 0,1,0,0,0, 0,0,0,0);
        vecs[8]  = mk(0,1,0,c_BUSY,0,32'h200,32'h55,32'h33333333, 0,1,1,0,0, 0,0,32'h200,32'h55);
        vecs[9]  = mk(0,1,0,c_BUSY,0,32'h200,32'h55,32'h33333333, 0,1,1,0,0, 0,0,32'h200,32'h55);
        vecs[10] = mk(0,1,0,c_BUSY,0,32'h200,32'h55,32'h33333333, 0,1,1,0,0, 0,0,32'h200,32'h55);
        vecs[11] = mk(0,1,0,c_ACC, 0,32'h200,32'h55,32'h33333333, 0,0,1,0,0, 0,32'h33333333,32'h200,32'h55);
        vecs[12] = mk(1,0,0,c_ERR, 32'h80,0,0,32'hBAD, 1,0,0,0,0, 0,0,0,0);
        vecs[13] = mk(1,0,0,c_ERR, 32'h80,0,0,32'hBAD, 0,0,1,0,0, 32'hBAD,0,32'h80,0);
        vecs[14] = mk(0,0,0,c_FREE,0,0,0,0,             0,0,0,0,1, 0,0,0,0);
        vecs[15] = mk(0,1,0,c_ACC, 0,32'h300,0,32'h44,  0,1,0,0,1, 0,0,0,0);
        vecs[16] = mk(0,1,0,c_ACC, 0,32'h300,0,32'h44,  0,0,1,0,1, 0,32'h44,32'h300,0);
        vecs[17] = mk(0,1,0,c_BUSY,0,32'h400,32'h77,0,  0,1,0,0,1, 0,0,0,0);
        vecs[18] = mk(0,0,0,c_BUSY,0,32'h400,32'h77,0,  0,0,0,0,1, 0,0,32'h400,32'h77);
        vecs[19] = mk(1,0,0,c_ACC, 32'h90,0,0,32'h66,   1,0,0,0,1, 0,0,0,0);
        vecs[20] = mk(1,0,0,c_ACC, 32'h90,0,0,32'h66,   0,0,1,0,1, 32'h66,0,32'h90,0);
        vecs[21] = mk(0,0,0,c_FREE,0,0,0,0,             0,0,0,0,1, 0,0,0,0);

        // reset state: waits mirror requests, everything else zero
        nRST = 1'b0;
        drive(1, 0, 1, c_ACC, 32'h40, 32'h100, 32'hDEAD, 32'h1234);
        #2;
        check("reset", w_act, {1'b1, 1'b1, 4'b0, 128'b0});
        drive(0, 0, 0, c_FREE, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(posedge CLK);
            #1;
            drive(vecs[i].ire, vecs[i].dre, vecs[i].dwe, vecs[i].rs,
                  vecs[i].ia, vecs[i].da, vecs[i].ds, vecs[i].rl);
            #1;
            check($sformatf("vec%0d", i), w_act, vecs[i].exp);
        end

        // data streak: dREN held with fetch pending, every access completes at once
        #3;
        nRST = 1'b0;
        drive(1, 1, 0, c_ACC, 32'h500, 32'h600, 0, 32'hCAFE);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("err_cleared", {133'b0, err}, 134'b0);
        for (int n = 0; n < 12; n++) begin
            int code;
            if (n != 0) begin
                @(posedge CLK);
                #2;
            end
            code = !ramREN ? 0 : (ramaddr == 32'h600) ? 1 : (ramaddr == 32'h500) ? 2 : 3;
            check($sformatf("streak%0d", n), 134'(code), 134'(exp_seq[n]));
        end

        // RAM hang: timeout after 64 grant cycles, then reset mid-grant
        #3;
        nRST = 1'b0;
        drive(0, 1, 0, c_BUSY, 0, 32'h700, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #2;
        for (int n = 1; n <= 65; n++) begin
            if (n != 1) begin
                @(posedge CLK);
                #2;
            end
            if (n == 64) check("timeout_g64", {131'b0, timeout, ramREN, dwait}, {131'b0, 3'b011});
            if (n == 65) check("timeout_g65", {131'b0, timeout, ramREN, dwait}, {131'b0, 3'b111});
        end
        #2;
        nRST = 1'b0;
        #1;
        check("reset_midgrant", w_act, {1'b0, 1'b1, 4'b0, 128'b0});
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("after_reset_idle", {130'b0, ramREN, ramWEN, timeout, err}, 134'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
